bus_ctrl_issue: RTL and testbench

// - Issue stage driving the encoded control fields consumed by BusControl (Bus_Assert, Bus_Load, Xfer_Assert,

---
 rtl/bus_ctrl_issue.sv | 158 +++++++++++++++
 tb/tb_bus_ctrl_issue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl_issue.sv
// Issue stage for BusControl: 2-entry skid FIFO of decoded control words, memory-word hold on Mem_Ready.
// Optional head-word sanity check is compiled in with `define BUSCTRL_CHECK_EN.
module bus_ctrl_issue #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Flush,
  input  logic        Cw_Valid,
  output logic        Cw_Ready,
  input  logic [25:0] Cw_Word,
  input  logic        Mem_Ready,
  output logic [3:0]  Bus_Assert,
  output logic [3:0]  Bus_Load,
  output logic [2:0]  Xfer_Assert,
  output logic [3:0]  XferLoadDec,
  output logic [1:0]  Inc_PCRA,
  output logic [1:0]  Inc_SPSIDI,
  output logic [1:0]  LHS,
  output logic [1:0]  RHS,
  output logic [2:0]  AddrSel,
  output logic        Issue_Valid,
  output logic        Mem_Stall,
  output logic        Mem_Timeout,
  output logic        Cw_Error
);

  // Codes that decode to no strobes in BusControl (AddrSel=0 is Memory_Ack, so idle is 7).
  localparam logic [25:0] IDLE_WORD = {4'h0, 4'h0, 3'h0, 4'h0, 2'h3, 2'h0, 2'h0, 2'h0, 3'h7};
  localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);

  logic [25:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]  count_q, count_d;
  logic [25:0] out_q, out_d;
  logic        issue_valid_q, issue_valid_d;
  logic        mem_stall_q, mem_stall_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  wait_q, wait_d;

  logic        push, head_valid, head_mem, issuable, stalled;
  logic [25:0] head;
  logic        slot;

`ifdef BUSCTRL_CHECK_EN
  logic error_q, error_d;
  logic head_bad;
  assign Cw_Error = error_q;
`else
  assign Cw_Error = 1'b0;
`endif

  // Handshake: a word transfers on an edge where Cw_Valid && Cw_Ready; Cw_Ready depends on count only,
  // so the producer may hold Cw_Valid/Cw_Word until it sees Cw_Ready high at an edge.
  assign Cw_Ready = (count_q != 2'd2);

  always_comb begin
    push       = Cw_Valid && Cw_Ready;
    head_valid = (count_q != 2'd0) || push;
    head       = (count_q != 2'd0) ? ent0_q : Cw_Word;
    head_mem   = (head[25:22] == 4'hF) || (head[21:18] == 4'hF) || (head[14:11] == 4'h8);
    issuable   = head_valid && (!head_mem || Mem_Ready);
    stalled    = head_valid && head_mem && !Mem_Ready;
`ifdef BUSCTRL_CHECK_EN
    head_bad   = ((head[21:18] != 4'h0) && (head[25:22] == 4'h0)) ||
                 ((head[25:22] == head[21:18]) && (head[25:22] != 4'h0)) ||
                 ((head[14:11] >= 4'd1) && (head[14:11] <= 4'd6) &&
                  (head[17:15] == 3'h0) && (head[2:0] == 3'h7));
    error_d    = error_q;
`endif
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    count_d       = count_q;
    out_d         = out_q;
    issue_valid_d = issue_valid_q;
    mem_stall_d   = mem_stall_q;
    timeout_d     = timeout_q;
    wait_d        = wait_q;
    slot          = 1'b0;

    if (Flush) begin
      count_d       = 2'd0;
      out_d         = IDLE_WORD;
      issue_valid_d = 1'b0;
      mem_stall_d   = 1'b0;
      wait_d        = 8'd0;
    end else begin
      // Pop from storage first, then append; a bypassed word popped on arrival is never stored.
      if (issuable && count_q != 2'd0) begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      if (push && !(issuable && count_q == 2'd0)) begin
        slot = count_d[0];
        if (slot) ent1_d = Cw_Word;
        else      ent0_d = Cw_Word;
        count_d = count_d + 2'd1;
      end

      if (issuable) begin
        out_d         = head;
        issue_valid_d = 1'b1;
`ifdef BUSCTRL_CHECK_EN
        if (head_bad) begin
          out_d         = IDLE_WORD;
          issue_valid_d = 1'b0;
          error_d       = 1'b1;
        end
`endif
        mem_stall_d = 1'b0;
        wait_d      = 8'd0;
      end else begin
        out_d         = IDLE_WORD;
        issue_valid_d = 1'b0;
        mem_stall_d   = stalled;
        if (stalled) begin
          wait_d = (wait_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_q + 8'd1;
          if (wait_d == MAX_WAIT_C) timeout_d = 1'b1;
        end else begin
          wait_d = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      ent0_q        <= 26'h0;
      ent1_q        <= 26'h0;
      count_q       <= 2'd0;
      out_q         <= IDLE_WORD;
      issue_valid_q <= 1'b0;
      mem_stall_q   <= 1'b0;
      timeout_q     <= 1'b0;
      wait_q        <= 8'd0;
`ifdef BUSCTRL_CHECK_EN
      error_q       <= 1'b0;
`endif
    end else begin
      ent0_q        <= ent0_d;
      ent1_q        <= ent1_d;
      count_q       <= count_d;
      out_q         <= out_d;
      issue_valid_q <= issue_valid_d;
      mem_stall_q   <= mem_stall_d;
      timeout_q     <= timeout_d;
      wait_q        <= wait_d;
`ifdef BUSCTRL_CHECK_EN
      error_q       <= error_d;
`endif
    end
  end

  assign {Bus_Assert, Bus_Load, Xfer_Assert, XferLoadDec, Inc_PCRA, Inc_SPSIDI, LHS, RHS, AddrSel} = out_q;
  assign Issue_Valid = issue_valid_q;
  assign Mem_Stall   = mem_stall_q;
  assign Mem_Timeout = timeout_q;

endmodule

// File: tb/tb_bus_ctrl_issue.sv
// Bench for bus_ctrl_issue: directed scenarios plus randomized traffic against a queue-based model.
module tb_bus_ctrl_issue;
  localparam int MW = 3;
  localparam logic [25:0] IDLE_W = 26'h0000607;
`ifdef BUSCTRL_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic        Clock_In = 1'b0;
  logic        Reset_In, Flush, Cw_Valid, Mem_Ready;
  logic [25:0] Cw_Word;
  logic        Cw_Ready;
  logic [3:0]  Bus_Assert, Bus_Load, XferLoadDec;
  logic [2:0]  Xfer_Assert, AddrSel;
  logic [1:0]  Inc_PCRA, Inc_SPSIDI, LHS, RHS;
  logic        Issue_Valid, Mem_Stall, Mem_Timeout, Cw_Error;

  always #5 Clock_In = ~Clock_In;

  bus_ctrl_issue #(.MAX_WAIT(MW)) dut (
    .Clock_In(Clock_In), .Reset_In(Reset_In), .Flush(Flush), .Cw_Valid(Cw_Valid),
    .Cw_Ready(Cw_Ready), .Cw_Word(Cw_Word), .Mem_Ready(Mem_Ready),
    .Bus_Assert(Bus_Assert), .Bus_Load(Bus_Load), .Xfer_Assert(Xfer_Assert),
    .XferLoadDec(XferLoadDec), .Inc_PCRA(Inc_PCRA), .Inc_SPSIDI(Inc_SPSIDI),
    .LHS(LHS), .RHS(RHS), .AddrSel(AddrSel), .Issue_Valid(Issue_Valid),
    .Mem_Stall(Mem_Stall), .Mem_Timeout(Mem_Timeout), .Cw_Error(Cw_Error)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of pending words plus the expected registered outputs.
  logic [25:0] mq[$];
  logic [25:0] m_out = IDLE_W;
  logic        m_iv = 1'b0, m_stall = 1'b0, m_to = 1'b0, m_err = 1'b0;
  int          m_wait = 0;

  function automatic logic [25:0] obs();
    return {Bus_Assert, Bus_Load, Xfer_Assert, XferLoadDec, Inc_PCRA, Inc_SPSIDI, LHS, RHS, AddrSel};
  endfunction

  function automatic logic [25:0] mk(input logic [3:0] a, input logic [3:0] l);
    return {a, l, 3'd1, 4'd0, 2'd0, 2'd1, 2'd2, 2'd1, 3'd2};
  endfunction

  function automatic bit model_mem(input logic [25:0] w);
    return (w[25:22] == 4'hF) || (w[21:18] == 4'hF) || (w[14:11] == 4'h8);
  endfunction

  function automatic bit model_bad(input logic [25:0] w);
    int a, l, xa, xld, as;
    a = int'(w[25:22]); l = int'(w[21:18]); xa = int'(w[17:15]); xld = int'(w[14:11]); as = int'(w[2:0]);
    return (l != 0 && a == 0) || (a == l && a != 0) || (xld >= 1 && xld <= 6 && xa == 0 && as == 7);
  endfunction

  task automatic step();
    logic [25:0] w;
    if (Reset_In) begin
      mq.delete(); m_out = IDLE_W; m_iv = 0; m_stall = 0; m_to = 0; m_err = 0; m_wait = 0;
    end else if (Flush) begin
      mq.delete(); m_out = IDLE_W; m_iv = 0; m_stall = 0; m_wait = 0;
    end else begin
      if (Cw_Valid && mq.size() < 2) mq.push_back(Cw_Word);
      if (mq.size() == 0) begin
        m_out = IDLE_W; m_iv = 0; m_stall = 0; m_wait = 0;
      end else if (!model_mem(mq[0]) || Mem_Ready) begin
        w = mq.pop_front();
        m_stall = 0; m_wait = 0;
        if (CHECK_ON && model_bad(w)) begin
          m_out = IDLE_W; m_iv = 0; m_err = 1;
        end else begin
          m_out = w; m_iv = 1;
        end
      end else begin
        m_out = IDLE_W; m_iv = 0; m_stall = 1;
        if (m_wait < MW) m_wait++;
        if (m_wait == MW) m_to = 1;
      end
    end
    @(posedge Clock_In);
    #1;
  endtask

  task automatic do_reset();
    Reset_In = 1; step(); Reset_In = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (obs() !== IDLE_W) begin miscompares++; $display("FAIL reset_fields: got %h exp %h", obs(), IDLE_W); end
    vectors++; if (Issue_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_iv: got %b exp 0", Issue_Valid); end
    vectors++; if (Mem_Stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b exp 0", Mem_Stall); end
    vectors++; if (Mem_Timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b exp 0", Mem_Timeout); end
    vectors++; if (Cw_Error !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b exp 0", Cw_Error); end
    vectors++; if (Cw_Ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b exp 1", Cw_Ready); end
  endtask

  task automatic test_single_issue();
    Mem_Ready = 0; Cw_Valid = 1; Cw_Word = mk(4'd1, 4'd2);
    step(); Cw_Valid = 0;
    vectors++; if (obs() !== mk(4'd1, 4'd2)) begin miscompares++; $display("FAIL single_word: got %h exp %h", obs(), mk(4'd1, 4'd2)); end
    vectors++; if (Issue_Valid !== 1'b1) begin miscompares++; $display("FAIL single_iv: got %b exp 1", Issue_Valid); end
    step();
    vectors++; if (AddrSel !== 3'd7 || Inc_PCRA !== 2'd3) begin miscompares++; $display("FAIL single_idle: got AddrSel=%0d Inc_PCRA=%0d exp 7/3", AddrSel, Inc_PCRA); end
    vectors++; if (Issue_Valid !== 1'b0) begin miscompares++; $display("FAIL single_idle_iv: got %b exp 0", Issue_Valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    Mem_Ready = 0; Cw_Valid = 1; Cw_Word = mk(4'hF, 4'd0);
    step();
    vectors++; if (Mem_Stall !== 1'b1 || Issue_Valid !== 1'b0) begin miscompares++; $display("FAIL b2b_stall: got stall=%b iv=%b exp 1/0", Mem_Stall, Issue_Valid); end
    Cw_Word = mk(4'd1, 4'd2);
    step();
    vectors++; if (Cw_Ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full: got %b exp 0", Cw_Ready); end
    Cw_Word = mk(4'd2, 4'd3); Mem_Ready = 1;
    step();
    vectors++; if (Issue_Valid !== 1'b1 || Bus_Assert !== 4'hF) begin miscompares++; $display("FAIL b2b_first: got iv=%b BusA=%h exp 1/F", Issue_Valid, Bus_Assert); end
    step(); Cw_Valid = 0;
    vectors++; if (Issue_Valid !== 1'b1 || Bus_Assert !== 4'd1) begin miscompares++; $display("FAIL b2b_second: got iv=%b BusA=%h exp 1/1", Issue_Valid, Bus_Assert); end
    step();
    vectors++; if (Issue_Valid !== 1'b1 || Bus_Assert !== 4'd2 || Bus_Load !== 4'd3) begin miscompares++; $display("FAIL b2b_third: got iv=%b BusA=%h BusL=%h exp 1/2/3", Issue_Valid, Bus_Assert, Bus_Load); end
    step();
    vectors++; if (Issue_Valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b exp 0", Issue_Valid); end
  endtask

  task automatic test_timeout();
    do_reset();
    Mem_Ready = 0; Cw_Valid = 1; Cw_Word = mk(4'd0, 4'hF);
    step(); Cw_Valid = 0;
    step();
    vectors++; if (Mem_Timeout !== 1'b0) begin miscompares++; $display("FAIL to_early: got %b exp 0", Mem_Timeout); end
    step();
    vectors++; if (Mem_Timeout !== 1'b1 || Mem_Stall !== 1'b1) begin miscompares++; $display("FAIL to_set: got to=%b stall=%b exp 1/1", Mem_Timeout, Mem_Stall); end
    Mem_Ready = 1;
    step();
    vectors++; if (Issue_Valid !== 1'b1 || Bus_Load !== 4'hF || Mem_Timeout !== 1'b1) begin miscompares++; $display("FAIL to_issue: got iv=%b BusL=%h to=%b exp 1/F/1", Issue_Valid, Bus_Load, Mem_Timeout); end
    step();
    vectors++; if (Mem_Timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky: got %b exp 1", Mem_Timeout); end
  endtask

  task automatic test_flush();
    do_reset();
    Mem_Ready = 0; Cw_Valid = 1; Cw_Word = mk(4'hF, 4'd0);
    step(); Cw_Word = mk(4'd1, 4'd2);
    step();
    vectors++; if (Cw_Ready !== 1'b0) begin miscompares++; $display("FAIL flush_pre_full: got %b exp 0", Cw_Ready); end
    Flush = 1; Cw_Word = mk(4'd3, 4'd4);
    step(); Flush = 0; Cw_Valid = 0;
    vectors++; if (Cw_Ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b exp 1", Cw_Ready); end
    vectors++; if (obs() !== IDLE_W || Issue_Valid !== 1'b0 || Mem_Stall !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got %h iv=%b stall=%b exp %h/0/0", obs(), Issue_Valid, Mem_Stall, IDLE_W); end
    Mem_Ready = 1;
    step();
    vectors++; if (Issue_Valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped: got %b exp 0", Issue_Valid); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    Mem_Ready = 0; Cw_Valid = 1; Cw_Word = mk(4'hF, 4'd1);
    step(); Cw_Word = mk(4'd5, 4'd6);
    step(); Cw_Valid = 0;
    step(); step();
    vectors++; if (Mem_Stall !== 1'b1 || Mem_Timeout !== 1'b1 || Cw_Ready !== 1'b0) begin miscompares++; $display("FAIL rms_pre: got stall=%b to=%b rdy=%b exp 1/1/0", Mem_Stall, Mem_Timeout, Cw_Ready); end
    do_reset();
    vectors++; if (Cw_Ready !== 1'b1 || obs() !== IDLE_W || Issue_Valid !== 1'b0 || Mem_Timeout !== 1'b0 || Mem_Stall !== 1'b0) begin
      miscompares++; $display("FAIL rms_post: got rdy=%b fields=%h iv=%b to=%b stall=%b exp 1/%h/0/0/0", Cw_Ready, obs(), Issue_Valid, Mem_Timeout, Mem_Stall, IDLE_W);
    end
    Mem_Ready = 1;
    step();
    vectors++; if (Issue_Valid !== 1'b0) begin miscompares++; $display("FAIL rms_empty: got %b exp 0", Issue_Valid); end
  endtask

  task automatic test_check_word();
    do_reset();
    Mem_Ready = 1; Cw_Valid = 1; Cw_Word = mk(4'd0, 4'd3);
    step(); Cw_Valid = 0;
`ifdef BUSCTRL_CHECK_EN
    vectors++; if (Issue_Valid !== 1'b0 || Cw_Error !== 1'b1 || obs() !== IDLE_W) begin miscompares++; $display("FAIL check_reject: got iv=%b err=%b fields=%h exp 0/1/%h", Issue_Valid, Cw_Error, obs(), IDLE_W); end
`else
    vectors++; if (Issue_Valid !== 1'b1 || Bus_Load !== 4'd3 || Cw_Error !== 1'b0) begin miscompares++; $display("FAIL check_pass: got iv=%b BusL=%h err=%b exp 1/3/0", Issue_Valid, Bus_Load, Cw_Error); end
`endif
  endtask

  task automatic test_random();
    logic [25:0] w;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      Reset_In  = ($urandom_range(0, 99) == 0);
      Flush     = ($urandom_range(0, 39) == 0);
      Cw_Valid  = ($urandom_range(0, 9) < 7);
      Mem_Ready = ($urandom_range(0, 2) != 0);
      w = 26'($urandom);
      if ($urandom_range(0, 3) == 0) w[25:22] = 4'hF;
      Cw_Word = w;
      vectors++; if (Cw_Ready !== (mq.size() < 2)) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b exp %b", i, Cw_Ready, mq.size() < 2); end
      step();
      vectors++; if (obs() !== m_out) begin miscompares++; $display("FAIL rnd_fields[%0d]: got %h exp %h", i, obs(), m_out); end
      vectors++; if (Issue_Valid !== m_iv) begin miscompares++; $display("FAIL rnd_iv[%0d]: got %b exp %b", i, Issue_Valid, m_iv); end
      vectors++; if (Mem_Stall !== m_stall) begin miscompares++; $display("FAIL rnd_stall[%0d]: got %b exp %b", i, Mem_Stall, m_stall); end
      vectors++; if (Mem_Timeout !== m_to) begin miscompares++; $display("FAIL rnd_timeout[%0d]: got %b exp %b", i, Mem_Timeout, m_to); end
      vectors++; if (Cw_Error !== m_err) begin miscompares++; $display("FAIL rnd_err[%0d]: got %b exp %b", i, Cw_Error, m_err); end
    end
    Reset_In = 0; Flush = 0; Cw_Valid = 0;
  endtask

  initial begin
    Reset_In = 1; Flush = 0; Cw_Valid = 0; Mem_Ready = 0; Cw_Word = '0;
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_timeout();
    test_flush();
    test_reset_mid_stall();
    test_check_word();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
